// File: rtl/core_run_sequencer_if.sv
// Bundles the loader handshake, ISP write port, core control and status signals of the run sequencer.
// The master side drives the i_* signals; the sequencer (slave) drives the o_* signals.
interface core_run_sequencer_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 12,
  parameter int PROG_ADDR_BITS = 20
);
  logic                      i_go;
  logic                      i_abort;
  logic [ADDRESS_BITS-1:0]   i_load_len;
  logic                      i_ld_valid;
  logic [DATA_WIDTH-1:0]     i_ld_data;
  logic                      o_ld_ready;
  logic                      o_isp_write;
  logic [ADDRESS_BITS-1:0]   o_isp_address;
  logic [DATA_WIDTH-1:0]     o_isp_data;
  logic                      o_core_reset;
  logic                      o_core_start;
  logic [PROG_ADDR_BITS-1:0] o_core_prog_address;
  logic                      i_halt;
  logic                      o_report;
  logic                      o_busy;
  logic                      o_done;
  logic                      o_timeout;
  logic [31:0]               o_cycle_count;

  modport master (
    output i_go, i_abort, i_load_len, i_ld_valid, i_ld_data, i_halt,
    input  o_ld_ready, o_isp_write, o_isp_address, o_isp_data, o_core_reset,
           o_core_start, o_core_prog_address, o_report, o_busy, o_done,
           o_timeout, o_cycle_count
  );

  modport slave (
    input  i_go, i_abort, i_load_len, i_ld_valid, i_ld_data, i_halt,
    output o_ld_ready, o_isp_write, o_isp_address, o_isp_data, o_core_reset,
           o_core_start, o_core_prog_address, o_report, o_busy, o_done,
           o_timeout, o_cycle_count
  );
endinterface

// File: rtl/core_run_sequencer.sv
// Sequences one program run on the core: ISP load, reset hold, start pulse, cycle-counted run
// with halt/watchdog completion, then a one-cycle report pulse.
module core_run_sequencer #(
  parameter int                        DATA_WIDTH     = 32,
  parameter int                        ADDRESS_BITS   = 12,
  parameter int                        PROG_ADDR_BITS = 20,
  parameter logic [PROG_ADDR_BITS-1:0] PROG_START     = '0,
  parameter int                        RESET_CYCLES   = 10,
  parameter int                        RUN_CYCLES     = 100
) (
  input  logic                 clock,
  input  logic                 reset,
  core_run_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_START,
    S_RUN,
    S_REPORT,
    S_DONE
  } state_t;

  localparam logic [31:0] HOLD_LAST = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] RUN_LAST  = 32'(RUN_CYCLES - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDRESS_BITS-1:0] r_len;
  logic [ADDRESS_BITS-1:0] r_addr;
  logic [31:0]             r_holdCount;
  logic [31:0]             r_cycleCount;
  logic                    r_timeout;
  logic                    r_ispWrite;
  logic [ADDRESS_BITS-1:0] r_ispAddress;
  logic [DATA_WIDTH-1:0]   r_ispData;

  logic w_start;
  logic w_accept;
  logic w_lastWord;
  logic w_holdDone;
  logic w_runLimit;

  // Abort masks every action in its cycle, including a word offered on the loader handshake.
  assign w_start    = (r_state == S_IDLE || r_state == S_DONE) && bus.i_go && !bus.i_abort;
  assign w_accept   = (r_state == S_LOAD) && bus.i_ld_valid && !bus.i_abort;
  assign w_lastWord = w_accept && (r_addr == r_len - ADDRESS_BITS'(1));
  assign w_holdDone = (r_holdCount == HOLD_LAST);
  assign w_runLimit = (r_cycleCount == RUN_LAST);

  always_comb begin
    w_next = r_state;
    if (bus.i_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (bus.i_go) w_next = (bus.i_load_len != '0) ? S_LOAD : S_HOLD;
        S_LOAD:         if (w_lastWord) w_next = S_HOLD;
        S_HOLD:         if (w_holdDone) w_next = S_START;
        S_START:        w_next = S_RUN;
        S_RUN:          if (bus.i_halt || w_runLimit) w_next = S_REPORT;
        S_REPORT:       w_next = S_DONE;
        default:        w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_addr       <= '0;
      r_holdCount  <= '0;
      r_cycleCount <= '0;
      r_timeout    <= 1'b0;
      r_ispWrite   <= 1'b0;
      r_ispAddress <= '0;
      r_ispData    <= '0;
    end else begin
      r_state    <= w_next;
      r_ispWrite <= w_accept;
      if (w_start) begin
        r_len        <= bus.i_load_len;
        r_addr       <= '0;
        r_cycleCount <= '0;
        r_timeout    <= 1'b0;
      end
      if (w_accept) begin
        r_ispAddress <= r_addr;
        r_ispData    <= bus.i_ld_data;
        r_addr       <= r_addr + ADDRESS_BITS'(1);
      end
      if (r_state == S_HOLD && !bus.i_abort) begin
        r_holdCount <= r_holdCount + 32'd1;
      end else begin
        r_holdCount <= '0;
      end
      // The count saturates; halt in the final watchdog cycle still counts as a clean finish.
      if (r_state == S_RUN && !bus.i_abort) begin
        if (r_cycleCount != '1) r_cycleCount <= r_cycleCount + 32'd1;
        if (!bus.i_halt && w_runLimit) r_timeout <= 1'b1;
      end
    end
  end

  assign bus.o_ld_ready          = (r_state == S_LOAD);
  assign bus.o_isp_write         = r_ispWrite;
  assign bus.o_isp_address       = r_ispAddress;
  assign bus.o_isp_data          = r_ispData;
  assign bus.o_core_reset        = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_HOLD);
  assign bus.o_core_start        = (r_state == S_START);
  assign bus.o_core_prog_address = (r_state == S_START) ? PROG_START : '0;
  assign bus.o_report            = (r_state == S_REPORT);
  assign bus.o_busy              = (r_state == S_LOAD) || (r_state == S_HOLD) || (r_state == S_START) ||
                                   (r_state == S_RUN) || (r_state == S_REPORT);
  assign bus.o_done              = (r_state == S_DONE);
  assign bus.o_timeout           = r_timeout;
  assign bus.o_cycle_count       = r_cycleCount;

endmodule

// File: tb/tb_core_run_sequencer.sv
// Randomized and directed bench for core_run_sequencer, checked every cycle against a
// phase-flag model of a run plus literal expectations for each directed scenario.
module tb_core_run_sequencer;
  localparam int DW           = 32;
  localparam int AB           = 12;
  localparam int PAB          = 20;
  localparam int RESET_CYCLES = 10;
  localparam int RUN_CYCLES   = 100;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  core_run_sequencer_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .PROG_ADDR_BITS(PAB)) bus ();

  core_run_sequencer #(
    .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .PROG_ADDR_BITS(PAB), .PROG_START('0),
    .RESET_CYCLES(RESET_CYCLES), .RUN_CYCLES(RUN_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: which phase of a run is active, expressed as independent flags and countdowns.
  bit          mLoading, mStart, mRun, mReport, mDone, mTimeout, mWrite;
  int          mWordsLeft, mHoldLeft, mAddr, mWAddr;
  logic [31:0] mCount, mWData;

  logic [31:0] logAddr[$];
  logic [31:0] logData[$];
  int reportCount = 0;
  int startCount  = 0;
  int holdCycles  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic boundExpired(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic modelReset();
    mLoading = 0; mStart = 0; mRun = 0; mReport = 0; mDone = 0; mTimeout = 0; mWrite = 0;
    mWordsLeft = 0; mHoldLeft = 0; mAddr = 0; mWAddr = 0; mCount = '0; mWData = '0;
  endtask

  task automatic modelStep();
    bit idle;
    bit wr;
    idle = !(mLoading || mHoldLeft > 0 || mStart || mRun || mReport || mDone);
    wr = 0;
    if (bus.i_abort) begin
      mLoading = 0; mHoldLeft = 0; mStart = 0; mRun = 0; mReport = 0; mDone = 0;
    end else if ((idle || mDone) && bus.i_go) begin
      mDone = 0; mCount = '0; mTimeout = 0; mAddr = 0;
      mWordsLeft = int'(bus.i_load_len);
      if (mWordsLeft != 0) mLoading = 1;
      else mHoldLeft = RESET_CYCLES;
    end else if (mLoading) begin
      if (bus.i_ld_valid) begin
        wr = 1;
        mWAddr = mAddr;
        mWData = bus.i_ld_data;
        mAddr = (mAddr + 1) % (1 << AB);
        mWordsLeft--;
        if (mWordsLeft == 0) begin
          mLoading = 0;
          mHoldLeft = RESET_CYCLES;
        end
      end
    end else if (mHoldLeft > 0) begin
      mHoldLeft--;
      if (mHoldLeft == 0) mStart = 1;
    end else if (mStart) begin
      mStart = 0;
      mRun = 1;
    end else if (mRun) begin
      if (bus.i_halt || mCount == 32'(RUN_CYCLES - 1)) begin
        mRun = 0;
        mReport = 1;
        mTimeout = !bus.i_halt;
      end
      if (mCount != 32'hFFFF_FFFF) mCount = mCount + 1;
    end else if (mReport) begin
      mReport = 0;
      mDone = 1;
    end
    mWrite = wr;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) modelReset();
      else modelStep();
    end
  end

  // Every-cycle comparison against the model, plus the event log used by the literal checks.
  initial begin
    bit idle;
    forever begin
      @(negedge clock);
      idle = !(mLoading || mHoldLeft > 0 || mStart || mRun || mReport || mDone);
      checkOutput("ld_ready", bus.o_ld_ready, mLoading);
      checkOutput("isp_write", bus.o_isp_write, mWrite);
      if (mWrite) begin
        checkOutput("isp_address", bus.o_isp_address, mWAddr);
        checkOutput("isp_data", bus.o_isp_data, mWData);
      end
      checkOutput("core_reset", bus.o_core_reset, idle || mLoading || mHoldLeft > 0);
      checkOutput("core_start", bus.o_core_start, mStart);
      checkOutput("core_prog_address", bus.o_core_prog_address, 0);
      checkOutput("report", bus.o_report, mReport);
      checkOutput("busy", bus.o_busy, mLoading || mHoldLeft > 0 || mStart || mRun || mReport);
      checkOutput("done", bus.o_done, mDone);
      checkOutput("timeout", bus.o_timeout, mTimeout);
      checkOutput("cycle_count", bus.o_cycle_count, mCount);
      if (bus.o_isp_write === 1'b1) begin
        logAddr.push_back(32'(bus.o_isp_address));
        logData.push_back(bus.o_isp_data);
      end
      if (bus.o_report === 1'b1) reportCount++;
      if (bus.o_core_start === 1'b1) startCount++;
      if (bus.o_busy === 1'b1 && bus.o_core_reset === 1'b1 && bus.o_ld_ready === 1'b0) holdCycles++;
    end
  end

  task automatic clearLog();
    logAddr.delete();
    logData.delete();
    reportCount = 0;
    startCount = 0;
    holdCycles = 0;
  endtask

  task automatic applyStimulus(input logic [AB-1:0] len);
    @(negedge clock);
    bus.i_go = 1'b1;
    bus.i_load_len = len;
    @(negedge clock);
    bus.i_go = 1'b0;
    bus.i_load_len = AB'($urandom);
  endtask

  task automatic loadWords(input int n, input int gap, input bit randomGap, input logic [31:0] base);
    int waited;
    int g;
    for (int i = 0; i < n; i++) begin
      g = randomGap ? $urandom_range(gap, 0) : gap;
      bus.i_ld_valid = 1'b0;
      repeat (g) @(negedge clock);
      bus.i_ld_valid = 1'b1;
      bus.i_ld_data = base + 32'(i);
      waited = 0;
      while (bus.o_ld_ready !== 1'b1 && waited < 50) begin
        @(negedge clock);
        waited++;
      end
      if (waited >= 50) begin
        boundExpired("ld_ready wait");
        break;
      end
      @(negedge clock);
    end
    bus.i_ld_valid = 1'b0;
  endtask

  task automatic runPhase(input int haltAt, input int abortAt, input bit noisyGo, output bit aborted);
    int  n;
    bit  running;
    n = 0;
    aborted = 0;
    while (1) begin
      if (bus.o_done === 1'b1 || aborted) break;
      if (n >= 400) begin
        boundExpired("run completion");
        break;
      end
      running = bus.o_busy && !bus.o_core_reset && !bus.o_core_start && !bus.o_report;
      bus.i_halt  = running && (int'(bus.o_cycle_count) == haltAt);
      bus.i_abort = running && (int'(bus.o_cycle_count) == abortAt);
      bus.i_go    = noisyGo && ($urandom_range(3, 0) == 0);
      aborted     = bus.i_abort;
      @(negedge clock);
      n++;
    end
    bus.i_halt = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_go = 1'b0;
  endtask

  initial begin
    bit          ab;
    logic [31:0] base;
    int          len;
    bus.i_go = 0; bus.i_abort = 0; bus.i_load_len = '0; bus.i_ld_valid = 0;
    bus.i_ld_data = '0; bus.i_halt = 0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checkOutput("reset core_reset", bus.o_core_reset, 1);
    checkOutput("reset busy", bus.o_busy, 0);
    checkOutput("reset isp_write", bus.o_isp_write, 0);
    checkOutput("reset cycle_count", bus.o_cycle_count, 0);
    reset = 1'b1;
    clearLog();

    $display("[TB] three-word load, halt at run cycle 7");
    base = 32'hA0A0_0000;
    applyStimulus(3);
    loadWords(3, 0, 0, base);
    runPhase(7, -1, 0, ab);
    #1;
    checkOutput("t1 done", bus.o_done, 1);
    checkOutput("t1 timeout", bus.o_timeout, 0);
    checkOutput("t1 cycle_count", bus.o_cycle_count, 8);
    checkOutput("t1 writes", logAddr.size(), 3);
    for (int i = 0; i < 3 && i < logAddr.size(); i++) begin
      checkOutput("t1 write addr", logAddr[i], i);
      checkOutput("t1 write data", logData[i], base + 32'(i));
    end
    checkOutput("t1 hold cycles", holdCycles, 10);
    checkOutput("t1 start pulses", startCount, 1);
    checkOutput("t1 report pulses", reportCount, 1);
    clearLog();

    $display("[TB] empty load, watchdog timeout");
    applyStimulus(0);
    runPhase(-1, -1, 1, ab);
    #1;
    checkOutput("t2 done", bus.o_done, 1);
    checkOutput("t2 timeout", bus.o_timeout, 1);
    checkOutput("t2 cycle_count", bus.o_cycle_count, 100);
    checkOutput("t2 writes", logAddr.size(), 0);
    checkOutput("t2 hold cycles", holdCycles, 10);
    clearLog();

    $display("[TB] two words with valid gaps");
    applyStimulus(2);
    loadWords(2, 5, 0, 32'h1234_0000);
    runPhase(3, -1, 0, ab);
    #1;
    checkOutput("t3 writes", logAddr.size(), 2);
    if (logAddr.size() == 2) checkOutput("t3 second addr", logAddr[1], 1);
    checkOutput("t3 cycle_count", bus.o_cycle_count, 4);
    clearLog();

    $display("[TB] abort during run");
    applyStimulus(1);
    loadWords(1, 0, 0, 32'h5555_0000);
    runPhase(-1, 20, 0, ab);
    #1;
    checkOutput("t4 aborted", ab, 1);
    checkOutput("t4 core_reset", bus.o_core_reset, 1);
    checkOutput("t4 done", bus.o_done, 0);
    checkOutput("t4 busy", bus.o_busy, 0);
    checkOutput("t4 report pulses", reportCount, 0);
    clearLog();

    $display("[TB] async reset mid-load");
    applyStimulus(5);
    loadWords(2, 0, 0, 32'h7777_0000);
    bus.i_ld_valid = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t5 core_reset", bus.o_core_reset, 1);
    checkOutput("t5 busy", bus.o_busy, 0);
    checkOutput("t5 ld_ready", bus.o_ld_ready, 0);
    checkOutput("t5 isp_write", bus.o_isp_write, 0);
    bus.i_ld_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    clearLog();
    applyStimulus(1);
    loadWords(1, 0, 0, 32'h8888_0000);
    runPhase(3, -1, 0, ab);
    #1;
    checkOutput("t5 rerun done", bus.o_done, 1);
    checkOutput("t5 rerun cycle_count", bus.o_cycle_count, 4);
    checkOutput("t5 rerun writes", logAddr.size(), 1);
    clearLog();

    $display("[TB] halt on last watchdog cycle, then rerun from done");
    applyStimulus(0);
    runPhase(RUN_CYCLES - 1, -1, 0, ab);
    #1;
    checkOutput("t6 timeout", bus.o_timeout, 0);
    checkOutput("t6 cycle_count", bus.o_cycle_count, 100);
    applyStimulus(0);
    #1;
    checkOutput("t6 restart done", bus.o_done, 0);
    checkOutput("t6 restart core_reset", bus.o_core_reset, 1);
    checkOutput("t6 restart cycle_count", bus.o_cycle_count, 0);
    runPhase(5, -1, 0, ab);
    #1;
    checkOutput("t6 rerun cycle_count", bus.o_cycle_count, 6);
    clearLog();

    $display("[TB] abort drops a word in the same handshake");
    applyStimulus(3);
    bus.i_ld_valid = 1'b1;
    bus.i_ld_data = 32'hDEAD_BEEF;
    bus.i_abort = 1'b1;
    @(negedge clock);
    bus.i_abort = 1'b0;
    bus.i_ld_valid = 1'b0;
    #1;
    checkOutput("t7 isp_write", bus.o_isp_write, 0);
    checkOutput("t7 busy", bus.o_busy, 0);
    clearLog();

    $display("[TB] randomized runs");
    for (int r = 0; r < 12; r++) begin
      len = $urandom_range(4, 0);
      applyStimulus(AB'(len));
      loadWords(len, 3, 1, $urandom);
      runPhase($urandom_range(110, 0), ($urandom_range(4, 0) == 0) ? $urandom_range(50, 0) : -1, 1, ab);
      #1;
      checkOutput("rand writes", logAddr.size(), len);
      clearLog();
    end

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
